// File: rtl/phy_pkg.sv
// Shared PHY constants: K28.5 comma patterns, symbol width and the receive
// lock-state encoding used by both the transmit and receive paths.
package phy_pkg;

    localparam int unsigned SYMBOL_W = 10;

    localparam logic [SYMBOL_W-1:0] COMMA_K285_RDN = 10'b0011111010;
    localparam logic [SYMBOL_W-1:0] COMMA_K285_RDP = 10'b1100000101;

    localparam logic [1:0] UNLOCKED = 2'd0;
    localparam logic [1:0] CHECK    = 2'd1;
    localparam logic [1:0] LOCKED   = 2'd2;

    function automatic logic isK285(input logic [SYMBOL_W-1:0] sym);
        return (sym == COMMA_K285_RDN) || (sym == COMMA_K285_RDP);
    endfunction

endpackage

// File: rtl/idle_detector.sv
// Run-length counter on the serial line; flags electrical idle once IDLE_BITS
// identical bits have been sampled and reports the edge on which that happens.
module idle_detector #(
    parameter int unsigned IDLE_BITS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic enb,
    input  logic serialIn,
    output logic idleRise,
    output logic rxElecIdle
);

    localparam int unsigned RW = $clog2(IDLE_BITS + 1);
    localparam logic [RW-1:0] RunMax = RW'(IDLE_BITS);

    logic [RW-1:0] run;
    logic [RW-1:0] runNext;
    logic          prevBit;

    always_comb begin
        runNext = RW'(1);
        if (serialIn == prevBit) begin
            runNext = (run == RunMax) ? run : run + 1'b1;
        end
    end

    // Combinational so the lock FSM can drop lock on the same edge idle appears.
    assign idleRise   = enb && (runNext == RunMax) && (run != RunMax);
    assign rxElecIdle = (run == RunMax);

    always_ff @(posedge clk) begin
        if (!rst) begin
            run     <= '0;
            prevBit <= 1'b0;
        end else if (enb) begin
            run     <= runNext;
            prevBit <= serialIn;
        end
    end

endmodule

// File: rtl/rx_comma_aligner.sv
// Serial-to-symbol front end: hunts for K28.5, runs the lock FSM and emits
// boundary-aligned 10-bit symbols to the 8b/10b decoder.
module rx_comma_aligner
    import phy_pkg::*;
#(
    parameter int unsigned LOCK_COMMAS = 3,
    parameter int unsigned LOSS_COMMAS = 2,
    parameter int unsigned IDLE_BITS   = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enb,
    input  logic                serialIn,
    output logic [SYMBOL_W-1:0] symbolOut,
    output logic                symbolValid,
    output logic                isComma,
    output logic                locked,
    output logic                rxElecIdle
);

    localparam int unsigned CW = $clog2(LOCK_COMMAS + 1);
    localparam int unsigned MW = $clog2(LOSS_COMMAS + 1);
    localparam logic [CW-1:0] LockMax = CW'(LOCK_COMMAS);
    localparam logic [MW-1:0] LossMax = MW'(LOSS_COMMAS);

    logic [SYMBOL_W-1:0] sh;
    logic [SYMBOL_W-1:0] shNext;
    logic [3:0]          cnt;
    logic [3:0]          cntNext;
    logic [1:0]          state;
    logic [1:0]          stateNext;
    logic [CW-1:0]       commaCnt;
    logic [CW-1:0]       commaCntNext;
    logic [CW-1:0]       commaInc;
    logic [MW-1:0]       missCnt;
    logic [MW-1:0]       missCntNext;
    logic [MW-1:0]       missInc;
    logic                commaNow;
    logic                boundary;
    logic                emit;
    logic                idleRise;

    idle_detector #(
        .IDLE_BITS(IDLE_BITS)
    ) uIdle (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .serialIn  (serialIn),
        .idleRise  (idleRise),
        .rxElecIdle(rxElecIdle)
    );

    always_comb begin
        shNext       = {sh[SYMBOL_W-2:0], serialIn};
        commaNow     = isK285(shNext);
        boundary     = (cnt == 4'd9);
        cntNext      = boundary ? 4'd0 : cnt + 4'd1;
        commaInc     = commaCnt + 1'b1;
        missInc      = missCnt + 1'b1;
        stateNext    = state;
        commaCntNext = commaCnt;
        missCntNext  = missCnt;
        emit         = 1'b0;

        // Idle onset beats everything, including a coincident boundary.
        if (idleRise) begin
            stateNext    = UNLOCKED;
            cntNext      = 4'd0;
            commaCntNext = '0;
            missCntNext  = '0;
        end else begin
            case (state)
                UNLOCKED: begin
                    if (commaNow) begin
                        cntNext     = 4'd0;
                        missCntNext = '0;
                        if (LOCK_COMMAS <= 1) begin
                            stateNext    = LOCKED;
                            commaCntNext = '0;
                        end else begin
                            stateNext    = CHECK;
                            commaCntNext = CW'(1);
                        end
                    end
                end
                CHECK: begin
                    if (commaNow) begin
                        if (boundary) begin
                            if (commaInc == LockMax) begin
                                stateNext    = LOCKED;
                                commaCntNext = '0;
                                missCntNext  = '0;
                            end else begin
                                commaCntNext = commaInc;
                            end
                        end else begin
                            cntNext      = 4'd0;
                            commaCntNext = CW'(1);
                        end
                    end
                end
                LOCKED: begin
                    emit = boundary;
                    if (commaNow) begin
                        if (boundary) begin
                            missCntNext = '0;
                        end else if (missInc == LossMax) begin
                            stateNext   = UNLOCKED;
                            missCntNext = '0;
                        end else begin
                            missCntNext = missInc;
                        end
                    end
                end
                default: begin
                    stateNext = UNLOCKED;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sh          <= '0;
            cnt         <= '0;
            state       <= UNLOCKED;
            commaCnt    <= '0;
            missCnt     <= '0;
            symbolOut   <= '0;
            symbolValid <= 1'b0;
            isComma     <= 1'b0;
        end else if (enb) begin
            sh          <= shNext;
            cnt         <= cntNext;
            state       <= stateNext;
            commaCnt    <= commaCntNext;
            missCnt     <= missCntNext;
            symbolValid <= emit;
            if (emit) begin
                symbolOut <= shNext;
                isComma   <= commaNow;
            end
        end else begin
            symbolValid <= 1'b0;
        end
    end

    assign locked = (state == LOCKED);

endmodule
